// File: rtl/spike_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_enc_pkg
// Description : Shared constants, types and helpers for the spike event
//               encoder (timestamp type, control state, rate saturation).
// Revision    : 1.0 - initial release
// ============================================================================
package spike_enc_pkg;

    localparam int TS_W_DEF   = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int WINDOW_DEF = 16;
    localparam int RATE_W     = 8;
    localparam int RATE_MAX   = 255;

    typedef logic [TS_W_DEF-1:0] ts_t;
    typedef logic [RATE_W-1:0]   rate_t;

    // Control state is a direct decode of ena; no registered transition.
    typedef enum logic [0:0] {
        CTRL_HALT = 1'b0,
        CTRL_RUN  = 1'b1
    } ctrl_state_t;

    // Add a single event to a rate accumulator, holding at RATE_MAX.
    function automatic rate_t rate_sat_add(input rate_t acc, input logic inc);
        rate_t res;
        if (inc && (acc != rate_t'(RATE_MAX))) begin
            res = acc + rate_t'(1);
        end else begin
            res = acc;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_ts_fifo
// Description : Synchronous show-ahead FIFO. dout always shows the head
//               entry; level is a registered occupancy count. A push into a
//               full FIFO is accepted only when a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_ts_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_level_max = c_lw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_level == c_level_max);
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = pop & ~w_empty;
    // A full FIFO frees its head slot in the same cycle a pop happens.
    assign w_do_push = push & (~w_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + c_lw'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - c_lw'(1);
            end
        end
    end

    // Storage array; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/spike_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_encoder
// Description : Timestamps neuron spike events against a free-running cycle
//               counter, queues them in a show-ahead FIFO on a valid/ready
//               stream and reports a per-window spike-rate count.
//               Optional build macro SPIKE_EDGE_EN: only rising edges of the
//               spike level count as events.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_event_encoder
    import spike_enc_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WINDOW = WINDOW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     spike,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [RATE_W-1:0]        rate_count,
    output logic                     rate_valid
);

    localparam int c_win_w = $clog2(WINDOW);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);

    ctrl_state_t          w_state;
    logic                 w_run;
    logic                 w_ev;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [TS_W-1:0]      w_head_ts;

    logic [TS_W-1:0]      r_ts;
    logic [c_win_w-1:0]   r_win;
    rate_t                r_acc;
    rate_t                r_rate_count;
    logic                 r_rate_valid;
    logic                 r_overflow;

    // Control state is a pure decode of ena, so HALT/RUN take effect at once.
    always_comb begin
        w_state = CTRL_HALT;
        if (ena) begin
            w_state = CTRL_RUN;
        end
    end

    assign w_run = (w_state == CTRL_RUN);

`ifdef SPIKE_EDGE_EN
    logic r_spike_d;

    // Previous spike level, sampled only while running so HALT does not
    // disturb edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_d <= 1'b0;
        end else if (w_run) begin
            r_spike_d <= spike;
        end
    end

    assign w_ev = w_run & spike & ~r_spike_d;
`else
    assign w_ev = w_run & spike;
`endif

    // Free-running timestamp, frozen in HALT, wraps modulo 2^TS_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (w_run) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_pop = ~w_empty & evt_ready;

    spike_ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_ev),
        .pop   (w_pop),
        .din   (r_ts),
        .dout  (w_head_ts),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Sticky drop flag: an event arrived while full with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ev && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Rate window: accumulate events over WINDOW running cycles, then publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_acc        <= '0;
            r_rate_count <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= 1'b0;
            if (w_run) begin
                if (r_win == c_win_last) begin
                    r_win        <= '0;
                    r_rate_count <= rate_sat_add(r_acc, w_ev);
                    r_acc        <= '0;
                    r_rate_valid <= 1'b1;
                end else begin
                    r_win <= r_win + c_win_w'(1);
                    r_acc <= rate_sat_add(r_acc, w_ev);
                end
            end
        end
    end

    assign evt_valid  = ~w_empty;
    assign evt_ts     = w_head_ts;
    assign overflow   = r_overflow;
    assign rate_count = r_rate_count;
    assign rate_valid = r_rate_valid;

endmodule
`default_nettype wire
